arith_issue_queue: RTL and testbench

- Collapsing, age-ordered issue queue directly upstream of the middle-end arithmetic slot. Produces arith_instr/arith_valid.
- Holds renamed arithmetic ops from dispatch until all four physical source tags are ready.
- Snoops the middle-end completion tags for wakeup.
- Issues at most one op per cycle: the oldest ready op.

---
 rtl/arith_issue_queue.sv | 169 ++++++++++++++++
 tb/tb_arith_issue_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arith_issue_queue : collapsing, age-ordered issue queue for arithmetic ops  |
// | Optional: ARITH_IQ_WAKE_BYPASS_EN (same-cycle wakeup visible to selection)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 48
`endif
`ifndef PR_ADDR_W
`define PR_ADDR_W 5
`endif

module arith_issue_queue #(
   parameter int DEPTH = 8,
   parameter int OP_W  = `RENAMED_OP_SZ,
   parameter int TAG_W = `PR_ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [OP_W-1:0]        in_instr,
   input  logic                   in_valid,
   input  logic [3:0]             in_src_ready,
   output logic                   in_ready,
   input  logic [TAG_W*5-1:0]     wake_tags,
   input  logic [4:0]             wake_valid,
   output logic [OP_W-1:0]        issue_instr,
   output logic                   issue_valid,
   input  logic                   issue_ready,
   output logic [$clog2(DEPTH):0] occupancy
);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int OCC_W   = IDX_W + 1;
   localparam int SRC_LSB = 8;

   function automatic logic [3:0] f_src_hits(input logic [OP_W-1:0]    op,
                                             input logic [TAG_W*5-1:0] tags,
                                             input logic [4:0]         vld);
      logic [3:0] hit;
      hit = 4'b0000;
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 5; k++)
            if (vld[k] && (tags[k*TAG_W +: TAG_W] == op[SRC_LSB + i*TAG_W +: TAG_W]))
               hit[i] = 1'b1;
      return hit;
   endfunction

   function automatic logic [3:0] f_src_zero(input logic [OP_W-1:0] op);
      logic [3:0] z;
      for (int i = 0; i < 4; i++)
         z[i] = (op[SRC_LSB + i*TAG_W +: TAG_W] == '0);
      return z;
   endfunction

   logic [OP_W-1:0]  r_op [DEPTH];
   logic [3:0]       r_rdy [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [OCC_W-1:0] r_occ;
   logic [OP_W-1:0]  r_issue_instr;
   logic             r_issue_valid;

   logic [3:0]       w_hit [DEPTH];
   logic [3:0]       w_rdy_upd [DEPTH];
   logic [3:0]       w_sel_rdy [DEPTH];
   logic [OP_W-1:0]  w_nxt_op [DEPTH];
   logic [3:0]       w_nxt_rdy [DEPTH];
   logic [DEPTH-1:0] w_nxt_vld;
   logic             w_cand_found;
   logic [IDX_W-1:0] w_cand_idx;
   logic             w_load;
   logic             w_disp;
   logic [OCC_W-1:0] w_tail;
   logic [OCC_W-1:0] w_nxt_occ;
   logic [3:0]       w_in_rdy;

   assign in_ready    = (r_occ < OCC_W'(DEPTH));
   assign occupancy   = r_occ;
   assign issue_instr = r_issue_instr;
   assign issue_valid = r_issue_valid;

   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         w_hit[e]     = f_src_hits(r_op[e], wake_tags, wake_valid);
         w_rdy_upd[e] = r_rdy[e] | w_hit[e];
`ifdef ARITH_IQ_WAKE_BYPASS_EN
         w_sel_rdy[e] = w_rdy_upd[e];
`else
         w_sel_rdy[e] = r_rdy[e];
`endif
      end
   end

   // Descending scan so the lowest (oldest) ready index wins.
   always_comb begin
      w_cand_found = 1'b0;
      w_cand_idx   = '0;
      for (int e = DEPTH-1; e >= 0; e--) begin
         if (r_vld[e] && (&w_sel_rdy[e])) begin
            w_cand_found = 1'b1;
            w_cand_idx   = IDX_W'(e);
         end
      end
   end

   assign w_load    = w_cand_found && (!r_issue_valid || issue_ready);
   assign w_disp    = in_valid && in_ready;
   assign w_tail    = r_occ - OCC_W'(w_load);
   assign w_nxt_occ = w_tail + OCC_W'(w_disp);
   assign w_in_rdy  = in_src_ready | f_src_zero(in_instr) | f_src_hits(in_instr, wake_tags, wake_valid);

   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         w_nxt_op[e]  = r_op[e];
         w_nxt_rdy[e] = w_rdy_upd[e];
         w_nxt_vld[e] = r_vld[e];
      end
      if (w_load) begin
         for (int e = 0; e < DEPTH-1; e++) begin
            if (IDX_W'(e) >= w_cand_idx) begin
               w_nxt_op[e]  = r_op[e+1];
               w_nxt_rdy[e] = w_rdy_upd[e+1];
               w_nxt_vld[e] = r_vld[e+1];
            end
         end
         w_nxt_vld[DEPTH-1] = 1'b0;
      end
      // Dispatch lands at the post-collapse tail.
      for (int e = 0; e < DEPTH; e++) begin
         if (w_disp && (OCC_W'(e) == w_tail)) begin
            w_nxt_op[e]  = in_instr;
            w_nxt_rdy[e] = w_in_rdy;
            w_nxt_vld[e] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld         <= '0;
         r_occ         <= '0;
         r_issue_valid <= 1'b0;
         r_issue_instr <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            r_op[e]  <= '0;
            r_rdy[e] <= '0;
         end
      end else if (flush) begin
         r_vld         <= '0;
         r_occ         <= '0;
         r_issue_valid <= 1'b0;
      end else begin
         r_vld <= w_nxt_vld;
         r_occ <= w_nxt_occ;
         for (int e = 0; e < DEPTH; e++) begin
            r_op[e]  <= w_nxt_op[e];
            r_rdy[e] <= w_nxt_rdy[e];
         end
         if (w_load) begin
            r_issue_instr <= r_op[w_cand_idx];
            r_issue_valid <= 1'b1;
         end else if (r_issue_valid && issue_ready) begin
            r_issue_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_arith_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arith_issue_queue : self-checking bench for arith_issue_queue            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_arith_issue_queue;
   localparam int DEPTH = 8;
   localparam int OP_W  = 48;
   localparam int TAG_W = 5;
`ifdef ARITH_IQ_WAKE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic [OP_W-1:0]   in_instr;
   logic              in_valid;
   logic [3:0]        in_src_ready;
   logic              in_ready;
   logic [TAG_W*5-1:0] wake_tags;
   logic [4:0]        wake_valid;
   logic [OP_W-1:0]   issue_instr;
   logic              issue_valid;
   logic              issue_ready;
   logic [$clog2(DEPTH):0] occupancy;

   always #5 clk = ~clk;

   arith_issue_queue #(.DEPTH(DEPTH), .OP_W(OP_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_instr(in_instr), .in_valid(in_valid), .in_src_ready(in_src_ready), .in_ready(in_ready),
      .wake_tags(wake_tags), .wake_valid(wake_valid),
      .issue_instr(issue_instr), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .occupancy(occupancy)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [OP_W-1:0] exp_q[$];

   typedef struct {
      logic [4:0] s3, s2, s1, s0;
      logic [3:0] srdy;
      logic [4:0] dwv;
      logic [4:0] dwt;
      bit         now;
      logic [4:0] pend;
      int         lane;
   } vec_t;
   vec_t vt[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [OP_W-1:0] mk(input logic [7:0] id, input logic [4:0] s3, s2, s1, s0);
      logic [OP_W-1:0] op;
      op        = '0;
      op[7:0]   = id;
      op[27:8]  = {s3, s2, s1, s0};
      op[42:38] = 5'd3;
      return op;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [OP_W-1:0] op, input logic [3:0] srdy);
      in_instr     = op;
      in_src_ready = srdy;
      in_valid     = 1'b1;
   endtask

   // Scoreboard: every accepted handshake must match the next expected op.
   always @(negedge clk) begin
      if (!rst && issue_valid && issue_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_issue: got %0h expected none", issue_instr);
         end else begin
            check("issue_order", 64'(issue_instr), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      logic [OP_W-1:0] op;
      logic [OP_W-1:0] first_op;

      vt[0] = '{5'd0,  5'd0, 5'd0, 5'd0,  4'b0000, 5'b00000, 5'd0,  1'b1, 5'd0,  0};
      vt[1] = '{5'd3,  5'd4, 5'd0, 5'd6,  4'b1101, 5'b00000, 5'd0,  1'b1, 5'd0,  0};
      vt[2] = '{5'd0,  5'd0, 5'd9, 5'd0,  4'b0000, 5'b00000, 5'd0,  1'b0, 5'd9,  0};
      vt[3] = '{5'd0,  5'd0, 5'd0, 5'd12, 4'b0000, 5'b10000, 5'd12, 1'b1, 5'd0,  0};
      vt[4] = '{5'd31, 5'd2, 5'd0, 5'd0,  4'b0111, 5'b00000, 5'd0,  1'b0, 5'd31, 3};
      vt[5] = '{5'd0,  5'd7, 5'd0, 5'd0,  4'b0000, 5'b00010, 5'd8,  1'b0, 5'd7,  2};
      vt[6] = '{5'd0,  5'd0, 5'd1, 5'd1,  4'b0000, 5'b00000, 5'd0,  1'b0, 5'd1,  0};
      vt[7] = '{5'd0,  5'd0, 5'd0, 5'd20, 4'b0000, 5'b00000, 5'd20, 1'b0, 5'd20, 1};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_src_ready = '0;
      wake_tags = '0; wake_valid = '0; issue_ready = 1'b1;
      #12;
      check("rst_occupancy",   64'(occupancy),   64'd0);
      check("rst_issue_valid", 64'(issue_valid), 64'd0);
      check("rst_issue_instr", 64'(issue_instr), 64'd0);
      @(negedge clk); #1 rst = 1'b0;
      tick();
      check("in_ready_after_rst", 64'(in_ready), 64'd1);

      // Single-op vectors into an empty queue.
      for (int i = 0; i < 8; i++) begin
         op = mk(8'(i + 1), vt[i].s3, vt[i].s2, vt[i].s1, vt[i].s0);
         drive(op, vt[i].srdy);
         wake_valid = vt[i].dwv;
         wake_tags  = {5{vt[i].dwt}};
         exp_q.push_back(op);
         tick();
         in_valid = 1'b0; wake_valid = '0;
         check("vec_occ_dispatch", 64'(occupancy), 64'd1);
         tick();
         check("vec_issue_valid", 64'(issue_valid), 64'(vt[i].now));
         check("vec_occ_next", 64'(occupancy), vt[i].now ? 64'd0 : 64'd1);
         if (vt[i].now) begin
            check("vec_issue_instr", 64'(issue_instr), 64'(op));
            check("vec_rob_field", 64'(issue_instr[42:38]), 64'd3);
         end else begin
            wake_tags  = {5{vt[i].pend}};
            wake_valid = 5'(5'b1 << vt[i].lane);
            tick();
            wake_valid = '0;
            check("vec_wake_edge_m", 64'(issue_valid), 64'(BYP));
            tick();
            check("vec_wake_edge_m1", 64'(issue_valid), 64'(!BYP));
         end
         tick();
         check("vec_drained_valid", 64'(issue_valid), 64'd0);
         check("vec_drained_occ", 64'(occupancy), 64'd0);
      end

      // Younger ready op overtakes an older blocked op; wakeup then releases it.
      drive(mk(8'h20, 5'd0, 5'd0, 5'd7, 5'd0), 4'b1101);
      tick();
      drive(mk(8'h21, 5'd0, 5'd0, 5'd0, 5'd0), 4'b1111);
      exp_q.push_back(mk(8'h21, 5'd0, 5'd0, 5'd0, 5'd0));
      exp_q.push_back(mk(8'h20, 5'd0, 5'd0, 5'd7, 5'd0));
      tick();
      in_valid = 1'b0;
      check("age_occ2", 64'(occupancy), 64'd2);
      check("age_no_issue_yet", 64'(issue_valid), 64'd0);
      tick();
      check("age_c_first", 64'(issue_instr), 64'(mk(8'h21, 5'd0, 5'd0, 5'd0, 5'd0)));
      check("age_occ1", 64'(occupancy), 64'd1);
      wake_tags = '0; wake_tags[2*TAG_W +: TAG_W] = 5'd7; wake_valid = 5'b00100;
      tick();
      wake_valid = '0;
      check("age_wake_m", 64'(issue_valid), 64'(BYP));
      tick();
      check("age_wake_m1", 64'(issue_valid), 64'(!BYP));
      tick();
      check("age_drained", 64'(occupancy), 64'd0);

      // Removal and dispatch in the same cycle keep occupancy unchanged.
      drive(mk(8'h30, 5'd0, 5'd0, 5'd0, 5'd0), 4'b1111);
      exp_q.push_back(in_instr);
      tick();
      drive(mk(8'h31, 5'd0, 5'd0, 5'd0, 5'd0), 4'b1111);
      exp_q.push_back(in_instr);
      tick();
      in_valid = 1'b0;
      check("simul_occ", 64'(occupancy), 64'd1);
      check("simul_valid", 64'(issue_valid), 64'd1);
      tick();
      check("simul_second", 64'(issue_instr), 64'(mk(8'h31, 5'd0, 5'd0, 5'd0, 5'd0)));
      check("simul_occ0", 64'(occupancy), 64'd0);
      tick();

      // Fill with downstream stalled, then drain in order.
      issue_ready = 1'b0;
      first_op = mk(8'h40, 5'd0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 9; i++) begin
         op = mk(8'(8'h40 + i), 5'd0, 5'd0, 5'd0, 5'd0);
         exp_q.push_back(op);
         drive(op, 4'b1111);
         tick();
      end
      check("full_occ", 64'(occupancy), 64'd8);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_issue_hold", 64'(issue_instr), 64'(first_op));
      drive(mk(8'h4f, 5'd0, 5'd0, 5'd0, 5'd0), 4'b1111);
      tick();
      check("full_ignore_in", 64'(occupancy), 64'd8);
      issue_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("full_ignore_with_removal", 64'(occupancy), 64'd7);
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("drain_valid", 64'(issue_valid), 64'd1);
         check("drain_occ", 64'(occupancy), 64'(7 - k));
      end
      tick();
      check("drain_done", 64'(issue_valid), 64'd0);

      // Flush discards queue, issue register, and the flush-cycle dispatch/wakeup.
      issue_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i % 2 == 0) drive(mk(8'(8'h50 + i), 5'd0, 5'd0, 5'd0, 5'd0), 4'b1111);
         else            drive(mk(8'(8'h50 + i), 5'd0, 5'd0, 5'd0, 5'd15), 4'b1110);
         tick();
      end
      check("preflush_occ", 64'(occupancy), 64'd4);
      check("preflush_valid", 64'(issue_valid), 64'd1);
      flush = 1'b1;
      drive(mk(8'h5f, 5'd0, 5'd0, 5'd0, 5'd0), 4'b1111);
      wake_tags = {5{5'd15}}; wake_valid = 5'b00001;
      tick();
      flush = 1'b0; in_valid = 1'b0; wake_valid = '0;
      check("flush_occ", 64'(occupancy), 64'd0);
      check("flush_valid", 64'(issue_valid), 64'd0);
      issue_ready = 1'b1;
      tick(); tick();
      check("postflush_valid", 64'(issue_valid), 64'd0);
      check("postflush_occ", 64'(occupancy), 64'd0);

      // Asynchronous reset between edges.
      issue_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(mk(8'(8'h60 + i), 5'd0, 5'd0, 5'd0, 5'd0), 4'b1111);
         tick();
      end
      in_valid = 1'b0;
      check("prerst_valid", 64'(issue_valid), 64'd1);
      check("prerst_occ", 64'(occupancy), 64'd2);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(issue_valid), 64'd0);
      check("async_rst_occ", 64'(occupancy), 64'd0);
      @(negedge clk); #1 rst = 1'b0;
      tick();
      issue_ready = 1'b1;
      tick();
      check("postrst_idle", 64'(issue_valid), 64'd0);
      op = mk(8'h70, 5'd0, 5'd0, 5'd0, 5'd0);
      drive(op, 4'b1111);
      exp_q.push_back(op);
      tick();
      in_valid = 1'b0;
      tick();
      check("postrst_issue", 64'(issue_valid), 64'd1);
      check("postrst_instr", 64'(issue_instr), 64'(op));
      tick();
      check("postrst_drained", 64'(issue_valid), 64'd0);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
